lcd_spi_arb: RTL and testbench

Packet-level arbiter for the shared LCD SPI byte writer. Three requesters (init sequencer, draw engine, UART-driven command path) present byte streams with a D/C flag. The arbiter grants one whole packet at a time, owns the LCD chip select, and enforces a minimum CS-high gap between packets. It aborts packets stalled mid-stream. It sits between the requesters and the SPI shifter that drives `lcd_spi_sclk`/`lcd_spi_mosi`.

---
 rtl/lcd_spi_arb_if.sv | 27 ++
 rtl/lcd_spi_arb.sv | 155 +++++++++++++++
 tb/tb_lcd_spi_arb.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_spi_arb_if.sv
// Requester, SPI-writer and LCD chip-select signals of the LCD SPI arbiter.
// The arbiter connects through the slave modport; the requesters and writer connect through master.
interface lcd_spi_arb_if;
  logic [2:0]  s_valid;
  logic [23:0] s_data;
  logic [2:0]  s_dc;
  logic [2:0]  s_last;
  logic [2:0]  s_ready;
  logic        m_valid;
  logic [7:0]  m_data;
  logic        m_dc;
  logic        m_ready;
  logic        m_idle;
  logic        lcd_cs_n;
  logic [2:0]  grant;
  logic        abort;

  modport master (
    output s_valid, s_data, s_dc, s_last, m_ready, m_idle,
    input  s_ready, m_valid, m_data, m_dc, lcd_cs_n, grant, abort
  );

  modport slave (
    input  s_valid, s_data, s_dc, s_last, m_ready, m_idle,
    output s_ready, m_valid, m_data, m_dc, lcd_cs_n, grant, abort
  );
endinterface

// File: rtl/lcd_spi_arb.sv
// Packet arbiter for the shared LCD SPI byte writer: whole-packet grants, CS gap, stall abort.
// Define LCD_ARB_RR_EN for round-robin arbitration; otherwise fixed priority 0 > 1 > 2.
module lcd_spi_arb #(
  parameter int CS_GAP  = 2,
  parameter int TIMEOUT = 1000
) (
  input logic          clk,
  input logic          rst,
  lcd_spi_arb_if.slave bus
);

  typedef enum logic [1:0] {IDLE, XFER, DRAIN, GAP} state_t;

  localparam logic [7:0]  GAP_LOAD = 8'(CS_GAP);
  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_grant, w_grant_nxt;
  logic [7:0]  r_gap_cnt, w_gap_cnt_nxt;
  logic [15:0] r_to_cnt, w_to_cnt_nxt;
  logic        r_abort, w_abort_nxt;
  logic [1:0]  w_gidx;
  logic [1:0]  w_start;
  logic        w_own_valid;
  logic        w_own_last;
  logic        w_hs;

  // First requesting index found when searching upward (mod 3) from start.
  function automatic logic [2:0] pick(input logic [2:0] req, input logic [1:0] start);
    logic [2:0] g;
    int         idx;
    g = 3'b000;
    for (int k = 0; k < 3; k++) begin
      idx = (int'(start) + k) % 3;
      if (g == 3'b000 && req[idx]) g[idx] = 1'b1;
    end
    return g;
  endfunction

  function automatic logic sel_bit(input logic [2:0] v, input logic [1:0] idx);
    case (idx)
      2'd1:    return v[1];
      2'd2:    return v[2];
      default: return v[0];
    endcase
  endfunction

  function automatic logic [7:0] sel_byte(input logic [23:0] d, input logic [1:0] idx);
    case (idx)
      2'd1:    return d[15:8];
      2'd2:    return d[23:16];
      default: return d[7:0];
    endcase
  endfunction

  always_comb begin
    w_gidx = 2'd0;
    if (r_grant[1])      w_gidx = 2'd1;
    else if (r_grant[2]) w_gidx = 2'd2;
  end

  assign w_own_valid = sel_bit(bus.s_valid, w_gidx);
  assign w_own_last  = sel_bit(bus.s_last, w_gidx);
  assign w_hs        = (r_state == XFER) && w_own_valid && bus.m_ready;

  // Owner pass-through; data lines read zero whenever nobody owns the bus.
  assign bus.m_valid  = (r_state == XFER) && w_own_valid;
  assign bus.m_data   = (r_grant != 3'b000) ? sel_byte(bus.s_data, w_gidx) : 8'h00;
  assign bus.m_dc     = (r_grant != 3'b000) ? sel_bit(bus.s_dc, w_gidx) : 1'b0;
  assign bus.s_ready  = (r_state == XFER) ? (r_grant & {3{bus.m_ready}}) : 3'b000;
  assign bus.lcd_cs_n = !((r_state == XFER) || (r_state == DRAIN));
  assign bus.grant    = r_grant;
  assign bus.abort    = r_abort;

`ifdef LCD_ARB_RR_EN
  logic [1:0] r_ptr;
  logic       w_pkt_end;

  assign w_start   = r_ptr;
  assign w_pkt_end = (r_state == XFER) &&
                     ((w_hs && w_own_last) || (!w_own_valid && r_to_cnt == TO_LAST));

  always_ff @(posedge clk) begin
    if (rst)            r_ptr <= 2'd0;
    else if (w_pkt_end) r_ptr <= (w_gidx == 2'd2) ? 2'd0 : w_gidx + 2'd1;
  end
`else
  assign w_start = 2'd0;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_gap_cnt_nxt = r_gap_cnt;
    w_to_cnt_nxt  = r_to_cnt;
    w_abort_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (|bus.s_valid) begin
          w_grant_nxt  = pick(bus.s_valid, w_start);
          w_to_cnt_nxt = 16'd0;
          w_state_nxt  = XFER;
        end
      end
      XFER: begin
        // A last-byte handshake takes precedence over the stall timeout.
        if (w_hs && w_own_last) begin
          w_state_nxt  = DRAIN;
          w_to_cnt_nxt = 16'd0;
        end else if (w_own_valid) begin
          w_to_cnt_nxt = 16'd0;
        end else if (r_to_cnt == TO_LAST) begin
          w_state_nxt  = DRAIN;
          w_abort_nxt  = 1'b1;
          w_to_cnt_nxt = 16'd0;
        end else begin
          w_to_cnt_nxt = r_to_cnt + 16'd1;
        end
      end
      DRAIN: begin
        if (bus.m_idle) begin
          w_state_nxt   = GAP;
          w_grant_nxt   = 3'b000;
          w_gap_cnt_nxt = GAP_LOAD;
        end
      end
      GAP: begin
        if (r_gap_cnt <= 8'd1) begin
          w_state_nxt   = IDLE;
          w_gap_cnt_nxt = 8'd0;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt - 8'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_grant   <= 3'b000;
      r_gap_cnt <= 8'd0;
      r_to_cnt  <= 16'd0;
      r_abort   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_grant   <= w_grant_nxt;
      r_gap_cnt <= w_gap_cnt_nxt;
      r_to_cnt  <= w_to_cnt_nxt;
      r_abort   <= w_abort_nxt;
    end
  end

endmodule

// File: tb/tb_lcd_spi_arb.sv
// Directed bench for lcd_spi_arb (CS_GAP=2, TIMEOUT=8): cycle vectors plus contention, timeout and reset sequences.
module tb_lcd_spi_arb;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  lcd_spi_arb_if bus();

  lcd_spi_arb #(.CS_GAP(2), .TIMEOUT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs packed as {s_ready, m_valid, m_data, m_dc, lcd_cs_n, grant, abort}.
  typedef struct {
    logic [2:0]  vld;
    logic [23:0] data;
    logic [2:0]  dc;
    logic [2:0]  last;
    logic        mrdy;
    logic        midle;
    logic [17:0] ex;
  } vec_t;

  localparam logic [17:0] EX_IDLE = {3'b000, 1'b0, 8'h00, 1'b0, 1'b1, 3'b000, 1'b0};
  localparam int NVEC = 29;

  vec_t tbl[NVEC];

  function automatic vec_t mk(input logic [2:0] vld, input logic [23:0] d, input logic [2:0] dc,
                              input logic [2:0] lst, input logic mr, input logic mi,
                              input logic [17:0] ex);
    vec_t v;
    v.vld = vld; v.data = d; v.dc = dc; v.last = lst; v.mrdy = mr; v.midle = mi; v.ex = ex;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] vld, input logic [23:0] d, input logic [2:0] dc,
                       input logic [2:0] lst, input logic mr, input logic mi);
    bus.s_valid = vld; bus.s_data = d; bus.s_dc = dc; bus.s_last = lst;
    bus.m_ready = mr;  bus.m_idle = mi;
  endtask

  function automatic int gidx(input logic [2:0] g);
    if (g[1]) return 1;
    if (g[2]) return 2;
    return 0;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          pk[3];
    logic [2:0]  exp_g[3];
    logic [2:0]  prev_g;
    int          ng;
    int          last_hs;
    int          aborts;
    int          idx;
    logic [17:0] act;

    total = 0;
    bad   = 0;

    // Single packet from requester 1, including a non-owner request that must see no ready.
    tbl[0]  = mk(3'b010, 24'h002A00, 3'b000, 3'b000, 1'b1, 1'b1, EX_IDLE);
    tbl[1]  = mk(3'b010, 24'h002A00, 3'b000, 3'b000, 1'b1, 1'b1, {3'b010, 1'b1, 8'h2A, 1'b0, 1'b0, 3'b010, 1'b0});
    tbl[2]  = mk(3'b110, 24'hEE0000, 3'b010, 3'b000, 1'b1, 1'b1, {3'b010, 1'b1, 8'h00, 1'b1, 1'b0, 3'b010, 1'b0});
    tbl[3]  = mk(3'b010, 24'h001000, 3'b010, 3'b010, 1'b1, 1'b1, {3'b010, 1'b1, 8'h10, 1'b1, 1'b0, 3'b010, 1'b0});
    tbl[4]  = mk(3'b000, 24'h000000, 3'b000, 3'b000, 1'b1, 1'b1, {3'b000, 1'b0, 8'h00, 1'b0, 1'b0, 3'b010, 1'b0});
    tbl[5]  = mk(3'b010, 24'h005500, 3'b000, 3'b010, 1'b1, 1'b1, EX_IDLE);
    tbl[6]  = mk(3'b010, 24'h005500, 3'b000, 3'b010, 1'b1, 1'b1, EX_IDLE);
    tbl[7]  = mk(3'b010, 24'h005500, 3'b000, 3'b010, 1'b1, 1'b1, EX_IDLE);
    tbl[8]  = mk(3'b010, 24'h005500, 3'b000, 3'b010, 1'b1, 1'b1, {3'b010, 1'b1, 8'h55, 1'b0, 1'b0, 3'b010, 1'b0});
    tbl[9]  = mk(3'b000, 24'h000000, 3'b000, 3'b000, 1'b1, 1'b1, {3'b000, 1'b0, 8'h00, 1'b0, 1'b0, 3'b010, 1'b0});
    tbl[10] = mk(3'b000, 24'h000000, 3'b000, 3'b000, 1'b1, 1'b1, EX_IDLE);
    tbl[11] = mk(3'b000, 24'h000000, 3'b000, 3'b000, 1'b1, 1'b1, EX_IDLE);
    tbl[12] = mk(3'b000, 24'h000000, 3'b000, 3'b000, 1'b1, 1'b1, EX_IDLE);
    // Backpressure (m_ready 1,0,0,1) on a 4-byte packet from requester 0, then a 5-cycle drain.
    tbl[13] = mk(3'b001, 24'h0000A0, 3'b000, 3'b000, 1'b1, 1'b0, EX_IDLE);
    tbl[14] = mk(3'b001, 24'h0000A0, 3'b000, 3'b000, 1'b1, 1'b0, {3'b001, 1'b1, 8'hA0, 1'b0, 1'b0, 3'b001, 1'b0});
    tbl[15] = mk(3'b001, 24'h0000A1, 3'b001, 3'b000, 1'b0, 1'b0, {3'b000, 1'b1, 8'hA1, 1'b1, 1'b0, 3'b001, 1'b0});
    tbl[16] = mk(3'b001, 24'h0000A1, 3'b001, 3'b000, 1'b0, 1'b0, {3'b000, 1'b1, 8'hA1, 1'b1, 1'b0, 3'b001, 1'b0});
    tbl[17] = mk(3'b001, 24'h0000A1, 3'b001, 3'b000, 1'b1, 1'b0, {3'b001, 1'b1, 8'hA1, 1'b1, 1'b0, 3'b001, 1'b0});
    tbl[18] = mk(3'b001, 24'h0000A2, 3'b001, 3'b000, 1'b1, 1'b0, {3'b001, 1'b1, 8'hA2, 1'b1, 1'b0, 3'b001, 1'b0});
    tbl[19] = mk(3'b001, 24'h0000A3, 3'b001, 3'b001, 1'b1, 1'b0, {3'b001, 1'b1, 8'hA3, 1'b1, 1'b0, 3'b001, 1'b0});
    for (int i = 20; i < 25; i++)
      tbl[i] = mk(3'b000, 24'h000000, 3'b000, 3'b000, 1'b1, 1'b0, {3'b000, 1'b0, 8'h00, 1'b0, 1'b0, 3'b001, 1'b0});
    tbl[25] = mk(3'b000, 24'h000000, 3'b000, 3'b000, 1'b1, 1'b1, {3'b000, 1'b0, 8'h00, 1'b0, 1'b0, 3'b001, 1'b0});
    tbl[26] = mk(3'b000, 24'h000000, 3'b000, 3'b000, 1'b1, 1'b1, EX_IDLE);
    tbl[27] = mk(3'b000, 24'h000000, 3'b000, 3'b000, 1'b1, 1'b1, EX_IDLE);
    tbl[28] = mk(3'b000, 24'h000000, 3'b000, 3'b000, 1'b1, 1'b1, EX_IDLE);

    // Reset state with every request line active.
    rst = 1'b1;
    drive(3'b111, 24'hFFFFFF, 3'b111, 3'b111, 1'b1, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_cs_n",    32'(bus.lcd_cs_n), 32'd1);
    chk("rst_grant",   32'(bus.grant),    32'd0);
    chk("rst_m_valid", 32'(bus.m_valid),  32'd0);
    chk("rst_s_ready", 32'(bus.s_ready),  32'd0);
    chk("rst_abort",   32'(bus.abort),    32'd0);
    chk("rst_m_data",  32'(bus.m_data),   32'd0);
    chk("rst_m_dc",    32'(bus.m_dc),     32'd0);
    drive(3'b000, 24'h0, 3'b000, 3'b000, 1'b1, 1'b1);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive(tbl[i].vld, tbl[i].data, tbl[i].dc, tbl[i].last, tbl[i].mrdy, tbl[i].midle);
      #1;
      act = {bus.s_ready, bus.m_valid, bus.m_data, bus.m_dc, bus.lcd_cs_n, bus.grant, bus.abort};
      chk($sformatf("vec%0d", i), 32'(act), 32'(tbl[i].ex));
    end

    // Contention: requesters 0 (two packets) and 2 (one packet) request together.
    @(negedge clk);
    rst = 1'b1;
    drive(3'b000, 24'h0, 3'b000, 3'b000, 1'b1, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    pk[0] = 2; pk[1] = 0; pk[2] = 1;
`ifdef LCD_ARB_RR_EN
    exp_g[0] = 3'b001; exp_g[1] = 3'b100; exp_g[2] = 3'b001;
`else
    exp_g[0] = 3'b001; exp_g[1] = 3'b001; exp_g[2] = 3'b100;
`endif
    prev_g  = 3'b000;
    ng      = 0;
    last_hs = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      drive({pk[2] > 0, pk[1] > 0, pk[0] > 0}, 24'h121110, 3'b111, 3'b111, 1'b1, 1'b1);
      #1;
      if (bus.grant != 3'b000 && prev_g == 3'b000) begin
        if (ng < 3) chk($sformatf("cont_grant%0d", ng), 32'(bus.grant), 32'(exp_g[ng]));
        if (last_hs >= 0) chk("cont_gap", 32'(c - last_hs), 32'd5);
        ng++;
      end
      prev_g = bus.grant;
      if (bus.m_valid && bus.m_ready) begin
        idx = gidx(bus.grant);
        chk("cont_data", 32'(bus.m_data), 32'(8'h10 + 8'(idx)));
        if (pk[idx] > 0) pk[idx]--;
        last_hs = c;
      end
    end
    chk("cont_count", 32'(ng), 32'd3);

    // Timeout: requester 2 sends one byte then stalls.
    @(negedge clk);
    drive(3'b100, 24'h770000, 3'b000, 3'b000, 1'b1, 1'b1);
    #1;
    chk("to_idle_grant", 32'(bus.grant), 32'd0);
    @(negedge clk);
    #1;
    chk("to_grant",   32'(bus.grant),   32'b100);
    chk("to_byte_hs", 32'(bus.m_valid), 32'd1);
    aborts = 0;
    for (int s = 1; s <= 12; s++) begin
      @(negedge clk);
      drive(3'b000, 24'h0, 3'b000, 3'b000, 1'b1, 1'b1);
      #1;
      if (bus.abort) aborts++;
      if (s <= 8) chk($sformatf("to_noabort%0d", s), 32'(bus.abort), 32'd0);
      if (s == 9) begin
        chk("to_abort",      32'(bus.abort),    32'd1);
        chk("to_drain_gnt",  32'(bus.grant),    32'b100);
        chk("to_drain_cs",   32'(bus.lcd_cs_n), 32'd0);
      end
      if (s == 10) begin
        chk("to_abort_end",  32'(bus.abort),    32'd0);
        chk("to_gap_gnt",    32'(bus.grant),    32'd0);
        chk("to_gap_cs",     32'(bus.lcd_cs_n), 32'd1);
      end
    end
    chk("to_abort_count", 32'(aborts), 32'd1);

    // Reset while a packet is in XFER, with the request still pending.
    @(negedge clk);
    drive(3'b010, 24'h003300, 3'b000, 3'b000, 1'b0, 1'b1);
    #1;
    @(negedge clk);
    #1;
    chk("mx_grant",   32'(bus.grant),   32'b010);
    chk("mx_cs",      32'(bus.lcd_cs_n), 32'd0);
    chk("mx_m_valid", 32'(bus.m_valid), 32'd1);
    chk("mx_s_ready", 32'(bus.s_ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mx_rst_cs",      32'(bus.lcd_cs_n), 32'd1);
    chk("mx_rst_grant",   32'(bus.grant),    32'd0);
    chk("mx_rst_m_valid", 32'(bus.m_valid),  32'd0);
    chk("mx_rst_s_ready", 32'(bus.s_ready),  32'd0);
    @(negedge clk);
    #1;
    chk("mx_regrant",    32'(bus.grant),    32'b010);
    chk("mx_regrant_cs", 32'(bus.lcd_cs_n), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
